// File: rtl/tap_stream_fir.sv
// Double-banked streamed-coefficient FIR, one MAC per clock; sample_vld -> out_vld in NTAPS+1 cycles.
// No backpressure: samples arriving while busy are dropped and flagged by a one-cycle overrun pulse.
module tap_stream_fir #(
    parameter int NTAPS = 16,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tap_valid,
    input  logic [7:0]           tapnum,
    input  logic signed [DW-1:0] tapcoeff,
    input  logic signed [DW-1:0] sample_in,
    input  logic                 sample_vld,
    output logic signed [DW-1:0] sample_out,
    output logic                 out_vld,
    output logic                 busy,
    output logic                 overrun,
    output logic                 bank_sel
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PW = 2 * DW;
    localparam int AW = PW + IW;

    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [IW-1:0] NTAPS_W  = IW'(NTAPS);
    localparam logic [8:0]    NTAPS_L  = 9'(NTAPS);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         wp_q, wp_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]  sample_out_q, sample_out_d;
    logic                  out_vld_q, out_vld_d;
    logic                  overrun_q, overrun_d;
    logic                  bank_sel_q, bank_sel_d;
    logic                  swap_pend_q, swap_pend_d;

    logic signed [DW-1:0]  coef_q [0:1][0:NTAPS-1];
    logic signed [DW-1:0]  x_q    [0:NTAPS-1];

    logic                  tap_hit;
    logic                  tap_last;
    logic [IW-1:0]         tap_idx;
    logic                  x_we;
    logic [IW-1:0]         rd_idx;
    logic signed [DW-1:0]  coef_rd;
    logic signed [DW-1:0]  x_rd;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc_sum;
    logic signed [AW-1:0]  shifted;
    logic signed [DW-1:0]  sat_val;

    assign tap_hit  = tap_valid && ({1'b0, tapnum} < NTAPS_L);
    assign tap_last = tap_hit && ({1'b0, tapnum} == (NTAPS_L - 9'd1));
    assign tap_idx  = tapnum[IW-1:0];

    // Circular read: newest sample sits at wp, tap i looks i samples back.
    always_comb begin
        rd_idx = wp_q - idx_q;
        if (wp_q < idx_q) begin
            rd_idx = rd_idx + NTAPS_W;
        end
    end

    assign coef_rd = coef_q[bank_sel_q][idx_q];
    assign x_rd    = x_q[rd_idx];
    assign prod    = $signed({{DW{coef_rd[DW-1]}}, coef_rd}) * $signed({{DW{x_rd[DW-1]}}, x_rd});
    assign acc_sum = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
    assign shifted = acc_sum >>> (DW - 1);

    always_comb begin
        sat_val = shifted[DW-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat_val = OUT_MIN;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wp_d         = wp_q;
        acc_d        = acc_q;
        sample_out_d = sample_out_q;
        out_vld_d    = 1'b0;
        overrun_d    = 1'b0;
        bank_sel_d   = bank_sel_q;
        swap_pend_d  = swap_pend_q;
        x_we         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Swap lands on this edge, so a sample accepted now already runs on the new bank.
                if (swap_pend_q) begin
                    bank_sel_d  = ~bank_sel_q;
                    swap_pend_d = 1'b0;
                end
                if (sample_vld) begin
                    x_we    = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (sample_vld) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    sample_out_d = sat_val;
                    out_vld_d    = 1'b1;
                    state_d      = S_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_OUT: begin
                if (sample_vld) begin
                    overrun_d = 1'b1;
                end
                wp_d    = (wp_q == LAST_IDX) ? '0 : wp_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tap_last) begin
            swap_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            wp_q         <= '0;
            acc_q        <= '0;
            sample_out_q <= '0;
            out_vld_q    <= 1'b0;
            overrun_q    <= 1'b0;
            bank_sel_q   <= 1'b0;
            swap_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wp_q         <= wp_d;
            acc_q        <= acc_d;
            sample_out_q <= sample_out_d;
            out_vld_q    <= out_vld_d;
            overrun_q    <= overrun_d;
            bank_sel_q   <= bank_sel_d;
            swap_pend_q  <= swap_pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < NTAPS; t++) begin
                    coef_q[b][t] <= '0;
                end
            end
        end else if (tap_hit) begin
            coef_q[!bank_sel_q][tap_idx] <= tapcoeff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NTAPS; t++) begin
                x_q[t] <= '0;
            end
        end else if (x_we) begin
            x_q[wp_q] <= sample_in;
        end
    end

    assign sample_out = sample_out_q;
    assign out_vld    = out_vld_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign bank_sel   = bank_sel_q;

endmodule

// File: tb/tb_tap_stream_fir.sv
// Directed bench for tap_stream_fir: tap streaming, bank swap, FIR results, saturation, overrun, reset abort.
module tb_tap_stream_fir;

    localparam int NTAPS = 16;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          tap_valid;
    logic [7:0]    tapnum;
    logic [DW-1:0] tapcoeff;
    logic [DW-1:0] sample_in;
    logic          sample_vld;
    logic [DW-1:0] sample_out;
    logic          out_vld;
    logic          busy;
    logic          overrun;
    logic          bank_sel;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] tv [NTAPS];
    logic [DW-1:0] y;
    int            lat;
    int            vld_seen;

    always #5 clk = ~clk;

    tap_stream_fir #(.NTAPS(NTAPS), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tap_valid  (tap_valid),
        .tapnum     (tapnum),
        .tapcoeff   (tapcoeff),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .sample_out (sample_out),
        .out_vld    (out_vld),
        .busy       (busy),
        .overrun    (overrun),
        .bank_sel   (bank_sel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        tap_valid  = 1'b0;
        tapnum     = '0;
        tapcoeff   = '0;
        sample_in  = '0;
        sample_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic write_tap(input logic [7:0] n, input logic [DW-1:0] c);
        @(posedge clk);
        #1;
        tap_valid = 1'b1;
        tapnum    = n;
        tapcoeff  = c;
        @(posedge clk);
        #1;
        tap_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < NTAPS; i++) begin
            write_tap(8'(i), tv[i]);
        end
    endtask

    task automatic clear_tv();
        for (int i = 0; i < NTAPS; i++) begin
            tv[i] = '0;
        end
    endtask

    // Cycle 0 is the cycle sample_vld is high; returns at the negedge of the out_vld cycle.
    task automatic send(input logic [DW-1:0] s, output logic [DW-1:0] yo, output int lo);
        @(posedge clk);
        #1;
        sample_in  = s;
        sample_vld = 1'b1;
        @(posedge clk);
        #1;
        sample_vld = 1'b0;
        lo = 0;
        yo = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_vld) begin
                lo = k;
                yo = sample_out;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_sample_out", 32'(sample_out), 32'h0);
        chk("rst_out_vld",    32'(out_vld),    32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        chk("rst_bank_sel",   32'(bank_sel),   32'h0);

        // T1: empty banks give zero output with NTAPS+1 latency
        send(16'h4000, y, lat);
        chk("t1_latency", 32'(lat), 32'd17);
        chk("t1_out",     32'(y),   32'h0000);
        chk("t1_busy_out", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t1_vld_pulse", 32'(out_vld), 32'h0);
        chk("t1_idle",      32'(busy),    32'h0);

        // T2: single unity-ish tap, swap to bank 1
        clear_tv();
        tv[0] = 16'h7FFF;
        load_all();
        repeat (2) @(posedge clk);
        #1;
        chk("t2_bank_sel", 32'(bank_sel), 32'h1);
        send(16'h4000, y, lat);
        chk("t2_out", 32'(y), 32'h3FFF);
        @(negedge clk);
        chk("t2_hold", 32'(sample_out), 32'h3FFF);

        // T3: four-tap averager impulse response
        do_reset();
        clear_tv();
        for (int i = 0; i < 4; i++) tv[i] = 16'h2000;
        load_all();
        send(16'h7FFF, y, lat);
        chk("t3_out0", 32'(y), 32'h1FFF);
        for (int i = 1; i < 5; i++) begin
            send(16'h0000, y, lat);
            chk($sformatf("t3_out%0d", i), 32'(y), (i < 4) ? 32'h1FFF : 32'h0000);
        end

        // T4: saturation at both rails
        do_reset();
        for (int i = 0; i < NTAPS; i++) tv[i] = 16'h7FFF;
        load_all();
        for (int i = 0; i < NTAPS; i++) begin
            send(16'h7FFF, y, lat);
            if (i == 0)  chk("t4_first", 32'(y), 32'h7FFE);
            if (i == 15) chk("t4_pos_sat", 32'(y), 32'h7FFF);
        end
        for (int i = 0; i < NTAPS; i++) begin
            send(16'h8000, y, lat);
            if (i == 15) chk("t4_neg_sat", 32'(y), 32'h8000);
        end

        // T5: tap set completed mid-MAC, out-of-range tapnum ignored
        do_reset();
        clear_tv();
        tv[0] = 16'h7FFF;
        load_all();
        write_tap(8'd0, 16'h2000);
        fork
            send(16'h4000, y, lat);
            begin
                repeat (6) @(posedge clk);
                write_tap(8'd15, 16'h0000);
                write_tap(8'h20, 16'h7FFF);
            end
        join
        chk("t5_old_bank_out", 32'(y), 32'h3FFF);
        chk("t5_bank_at_out",  32'(bank_sel), 32'h1);
        repeat (2) @(negedge clk);
        chk("t5_bank_swapped", 32'(bank_sel), 32'h0);
        send(16'h4000, y, lat);
        chk("t5_new_bank_out", 32'(y), 32'h1000);

        // T6: overrun during MAC drops the sample
        do_reset();
        clear_tv();
        tv[0] = 16'h7FFF;
        tv[1] = 16'h2000;
        load_all();
        send(16'h4000, y, lat);
        chk("t6_out0", 32'(y), 32'h3FFF);
        fork
            send(16'h2000, y, lat);
            begin
                repeat (6) @(posedge clk);
                #1;
                sample_in  = 16'h7FFF;
                sample_vld = 1'b1;
                @(posedge clk);
                #1;
                sample_vld = 1'b0;
                chk("t6_overrun_pulse", 32'(overrun), 32'h1);
                chk("t6_busy",          32'(busy),    32'h1);
                @(posedge clk);
                #1;
                chk("t6_overrun_clear", 32'(overrun), 32'h0);
            end
        join
        chk("t6_out1", 32'(y), 32'h2FFF);
        send(16'h0000, y, lat);
        chk("t6_out2", 32'(y), 32'h0800);

        // Reset asserted mid-MAC aborts the sample
        @(posedge clk);
        #1;
        sample_in  = 16'h4000;
        sample_vld = 1'b1;
        @(posedge clk);
        #1;
        sample_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_out_vld",    32'(out_vld),    32'h0);
        chk("abort_sample_out", 32'(sample_out), 32'h0);
        chk("abort_busy",       32'(busy),       32'h0);
        chk("abort_overrun",    32'(overrun),    32'h0);
        chk("abort_bank_sel",   32'(bank_sel),   32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        vld_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_vld) vld_seen++;
        end
        chk("abort_no_out_vld", 32'(vld_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
